// File: rtl/core_ex_lsu_dmem_resp_if.sv
// Request/response bundle between the LSU (master) and the data-memory responder (slave).
interface core_ex_lsu_dmem_resp_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_wen;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [7:0]      req_wmask;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/core_ex_lsu_dmem_resp.sv
// Data-memory responder: one word-aligned request at a time, programmable
// response latency, byte-masked stores and an out-of-range error flag.
module core_ex_lsu_dmem_resp #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH_W   = 12,
  parameter logic [XLEN-1:0] BASE_ADDR = XLEN'(32'h8000_0000),
  parameter int              LATENCY   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  core_ex_lsu_dmem_resp_if.slave bus
);

  localparam int            NB    = XLEN / 8;
  localparam int            DEPTH = 1 << DEPTH_W;
  localparam logic [XLEN:0] SPAN  = (XLEN+1)'(1) << (DEPTH_W + 2);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                accept;
  logic                enterResp;
  logic                memWe;

  logic [XLEN-1:0]     reqOffset;
  logic                reqInRange;
  logic [DEPTH_W-1:0]  reqIdx;

  logic                wen_q;
  logic [DEPTH_W-1:0]  idx_q;
  logic [XLEN-1:0]     wdata_q;
  logic [NB-1:0]       wmask_q;
  logic                inRange_q;

  logic                opFromReq;
  logic                opWen;
  logic [DEPTH_W-1:0]  opIdx;
  logic [XLEN-1:0]     opWdata;
  logic [NB-1:0]       opWmask;
  logic                opInRange;

  logic [XLEN-1:0]     rdata_q;
  logic                rspErr_q;
  logic                unusedWmask;

  logic [XLEN-1:0]     mem [DEPTH];

  assign accept     = bus.req_valid & (state_q == IDLE);
  assign reqOffset  = bus.req_addr - BASE_ADDR;
  assign reqInRange = (bus.req_addr >= BASE_ADDR) && ({1'b0, reqOffset} < SPAN);
  assign reqIdx     = reqOffset[DEPTH_W+1:2];

  // With zero latency the response is produced on the accept edge, so the
  // operation fields come straight from the bus; otherwise from the capture regs.
  assign opFromReq = (state_q == IDLE);
  assign opWen     = opFromReq ? bus.req_wen              : wen_q;
  assign opIdx     = opFromReq ? reqIdx                   : idx_q;
  assign opWdata   = opFromReq ? bus.req_wdata            : wdata_q;
  assign opWmask   = opFromReq ? bus.req_wmask[NB-1:0]    : wmask_q;
  assign opInRange = opFromReq ? reqInRange               : inRange_q;

  assign memWe = enterResp & opWen & opInRange & ~rst;

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = rspErr_q;

  assign unusedWmask = ^bus.req_wmask;

  // State and latency counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; flags the edge on which the memory access happens.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    enterResp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d   = RESP;
            enterResp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY);
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d   = RESP;
          enterResp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the request on accept so later bus changes cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      inRange_q <= 1'b0;
    end else if (accept) begin
      wen_q     <= bus.req_wen;
      idx_q     <= reqIdx;
      wdata_q   <= bus.req_wdata;
      wmask_q   <= bus.req_wmask[NB-1:0];
      inRange_q <= reqInRange;
    end
  end

  // Response registers: load data or error on entry to RESP, clear error on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      rspErr_q <= 1'b0;
    end else if (enterResp) begin
      rspErr_q <= ~opInRange;
      rdata_q  <= (~opWen & opInRange) ? mem[opIdx] : '0;
    end else if ((state_q == RESP) && bus.rsp_ready) begin
      rspErr_q <= 1'b0;
    end
  end

  // Byte-lane masked store into the unreset memory array.
  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int k = 0; k < NB; k++) begin
        if (opWmask[k]) mem[opIdx][8*k +: 8] <= opWdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_core_ex_lsu_dmem_resp.sv
// Directed bench for core_ex_lsu_dmem_resp: one zero-latency and one
// three-cycle-latency instance, checked against a word model and scoreboard.
module tb_core_ex_lsu_dmem_resp;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acceptCycle;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t        sbQ[$];
  logic [31:0] model0 [int];
  logic [31:0] model3 [int];
  logic [31:0] lastRdata;

  core_ex_lsu_dmem_resp_if #(.XLEN(32)) if0 ();
  core_ex_lsu_dmem_resp_if #(.XLEN(32)) if3 ();

  core_ex_lsu_dmem_resp #(
    .XLEN(32), .DEPTH_W(12), .BASE_ADDR(32'h8000_0000), .LATENCY(0)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );

  core_ex_lsu_dmem_resp #(
    .XLEN(32), .DEPTH_W(12), .BASE_ADDR(32'h8000_0000), .LATENCY(3)
  ) dut3 (
    .clk(clk), .rst(rst), .bus(if3)
  );

  // Free-running clock and edge counter.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something stalls beyond every bounded wait.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic rdyOf(input bit sel);
    return sel ? if3.req_ready : if0.req_ready;
  endfunction

  function automatic logic valOf(input bit sel);
    return sel ? if3.rsp_valid : if0.rsp_valid;
  endfunction

  function automatic logic [31:0] rdataOf(input bit sel);
    return sel ? if3.rsp_rdata : if0.rsp_rdata;
  endfunction

  function automatic logic errOf(input bit sel);
    return sel ? if3.rsp_err : if0.rsp_err;
  endfunction

  function automatic logic [31:0] readModel(input bit sel, input int idx);
    if (sel) return model3.exists(idx) ? model3[idx] : 32'h0;
    return model0.exists(idx) ? model0[idx] : 32'h0;
  endfunction

  task automatic writeModel(input bit sel, input int idx, input logic [31:0] val);
    if (sel) model3[idx] = val;
    else     model0[idx] = val;
  endtask

  task automatic driveReq(input bit sel, input bit valid, input bit wen,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [7:0] mask);
    if (sel) begin
      if3.req_valid = valid; if3.req_wen = wen; if3.req_addr = addr;
      if3.req_wdata = wdata; if3.req_wmask = mask;
    end else begin
      if0.req_valid = valid; if0.req_wen = wen; if0.req_addr = addr;
      if0.req_wdata = wdata; if0.req_wmask = mask;
    end
  endtask

  task automatic setRspReady(input bit sel, input bit r);
    if (sel) if3.rsp_ready = r;
    else     if0.rsp_ready = r;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request, wait for accept, and push the expected response.
  task automatic applyStimulus(input bit sel, input bit wen, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [7:0] mask,
                               input bit hold, input bit expectRsp, input string tag);
    exp_t        e;
    bit          accepted = 1'b0;
    int          acc = 0;
    int          idx;
    bit          inRange;
    logic [31:0] cur;
    driveReq(sel, 1'b1, wen, addr, wdata, mask);
    for (int n = 0; n < 40; n++) begin
      if (rdyOf(sel)) begin
        accepted = 1'b1;
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    checkOutput({tag, "_accepted"}, 32'(accepted), 32'd1);
    if (!accepted) begin
      driveReq(sel, 1'b0, 1'b0, 32'h0, 32'h0, 8'h0);
      return;
    end
    @(posedge clk);
    #1;
    if (!hold) driveReq(sel, 1'b0, 1'b0, 32'h0, 32'h0, 8'h0);
    if (expectRsp) begin
      inRange = (addr >= 32'h8000_0000) && (addr < 32'h8000_4000);
      idx = int'((addr - 32'h8000_0000) >> 2);
      e.acceptCycle = acc;
      e.lat = sel ? 3 : 0;
      if (!inRange) begin
        e.err = 1'b1;
        e.rdata = 32'h0;
      end else if (wen) begin
        cur = readModel(sel, idx);
        for (int k = 0; k < 4; k++) begin
          if (mask[k]) cur[8*k +: 8] = wdata[8*k +: 8];
        end
        writeModel(sel, idx, cur);
        e.err = 1'b0;
        e.rdata = 32'h0;
      end else begin
        e.err = 1'b0;
        e.rdata = readModel(sel, idx);
      end
      sbQ.push_back(e);
    end
  endtask

  // Wait for the response, compare against the scoreboard, optionally stall, then handshake.
  task automatic collectResponse(input bit sel, input int stall, input string tag);
    exp_t        e;
    bit          got = 1'b0;
    logic [31:0] held;
    if (sbQ.size() == 0) return;
    e = sbQ.pop_front();
    setRspReady(sel, stall == 0);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (valOf(sel)) begin
        got = 1'b1;
        break;
      end
      checkOutput({tag, "_busyReady"}, 32'(rdyOf(sel)), 32'd0);
    end
    checkOutput({tag, "_rspSeen"}, 32'(got), 32'd1);
    if (!got) begin
      setRspReady(sel, 1'b1);
      driveReq(sel, 1'b0, 1'b0, 32'h0, 32'h0, 8'h0);
      return;
    end
    checkOutput({tag, "_latency"}, 32'(cyc), 32'(e.acceptCycle + 1 + e.lat));
    checkOutput({tag, "_rdata"}, rdataOf(sel), e.rdata);
    checkOutput({tag, "_err"}, 32'(errOf(sel)), 32'(e.err));
    checkOutput({tag, "_respReady"}, 32'(rdyOf(sel)), 32'd0);
    held = rdataOf(sel);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      checkOutput({tag, "_stallValid"}, 32'(valOf(sel)), 32'd1);
      checkOutput({tag, "_stallRdata"}, rdataOf(sel), held);
      checkOutput({tag, "_stallReady"}, 32'(rdyOf(sel)), 32'd0);
    end
    setRspReady(sel, 1'b1);
    @(posedge clk);
    #1;
    driveReq(sel, 1'b0, 1'b0, 32'h0, 32'h0, 8'h0);
    @(negedge clk);
    checkOutput({tag, "_doneValid"}, 32'(valOf(sel)), 32'd0);
    checkOutput({tag, "_doneErr"}, 32'(errOf(sel)), 32'd0);
    checkOutput({tag, "_doneReady"}, 32'(rdyOf(sel)), 32'd1);
    checkOutput({tag, "_doneRdataHeld"}, rdataOf(sel), held);
    lastRdata = held;
  endtask

  task automatic txn(input bit sel, input bit wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [7:0] mask,
                     input int stall, input string tag);
    applyStimulus(sel, wen, addr, wdata, mask, 1'b0, 1'b1, tag);
    collectResponse(sel, stall, tag);
  endtask

  initial begin
    rst = 1'b1;
    driveReq(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h0);
    driveReq(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 8'h0);
    setRspReady(1'b0, 1'b1);
    setRspReady(1'b1, 1'b1);
    repeat (3) @(negedge clk);

    for (int s = 0; s < 2; s++) begin
      checkOutput("reset_reqReady", 32'(rdyOf(s[0])), 32'd1);
      checkOutput("reset_rspValid", 32'(valOf(s[0])), 32'd0);
      checkOutput("reset_rspRdata", rdataOf(s[0]), 32'd0);
      checkOutput("reset_rspErr", 32'(errOf(s[0])), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] zero-latency store/load and byte masks");
    txn(1'b0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'hF, 0, "l0_store");
    txn(1'b0, 1'b0, 32'h8000_0010, 32'h0, 8'h0, 0, "l0_load");
    checkOutput("l0_loadConst", lastRdata, 32'hDEAD_BEEF);
    txn(1'b0, 1'b1, 32'h8000_0010, 32'h1122_3344, 8'h2, 0, "l0_mask2");
    txn(1'b0, 1'b0, 32'h8000_0010, 32'h0, 8'h0, 0, "l0_loadMask2");
    checkOutput("l0_mask2Const", lastRdata, 32'hDEAD_33EF);
    txn(1'b0, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 8'h0, 0, "l0_mask0");
    txn(1'b0, 1'b0, 32'h8000_0013, 32'h0, 8'h0, 0, "l0_loadMask0");
    checkOutput("l0_mask0Const", lastRdata, 32'hDEAD_33EF);
    txn(1'b0, 1'b1, 32'h8000_0014, 32'hA5A5_0F0F, 8'h9, 0, "l0_mask9");
    txn(1'b0, 1'b0, 32'h8000_0014, 32'h0, 8'h0, 0, "l0_loadMask9");

    $display("[TB] range boundaries and errors");
    txn(1'b0, 1'b1, 32'h8000_0000, 32'h0123_4567, 8'hF, 0, "l0_word0");
    txn(1'b0, 1'b1, 32'h8000_3FFC, 32'h7654_3210, 8'hF, 0, "l0_lastWord");
    txn(1'b0, 1'b0, 32'h8000_3FFC, 32'h0, 8'h0, 0, "l0_loadLast");
    txn(1'b0, 1'b0, 32'h7FFF_FFFC, 32'h0, 8'h0, 0, "l0_errBelow");
    txn(1'b0, 1'b1, 32'h8001_0000, 32'hFFFF_FFFF, 8'hF, 0, "l0_errAlias");
    txn(1'b0, 1'b1, 32'h8000_4000, 32'hFFFF_FFFF, 8'hF, 0, "l0_errAbove");
    txn(1'b0, 1'b0, 32'h8000_0000, 32'h0, 8'h0, 0, "l0_loadWord0");
    checkOutput("l0_word0Const", lastRdata, 32'h0123_4567);

    $display("[TB] response backpressure");
    txn(1'b0, 1'b0, 32'h8000_0010, 32'h0, 8'h0, 5, "l0_stall");
    txn(1'b0, 1'b0, 32'h8000_0014, 32'h0, 8'h0, 0, "l0_afterStall");

    $display("[TB] three-cycle latency");
    txn(1'b1, 1'b1, 32'h8000_0020, 32'h55AA_55AA, 8'hF, 0, "l3_store");
    applyStimulus(1'b1, 1'b0, 32'h8000_0020, 32'h0, 8'h0, 1'b1, 1'b1, "l3_holdLoad");
    collectResponse(1'b1, 0, "l3_holdLoad");
    checkOutput("l3_loadConst", lastRdata, 32'h55AA_55AA);
    txn(1'b1, 1'b0, 32'h8000_0024, 32'h0, 8'h0, 2, "l3_errFree");
    txn(1'b1, 1'b0, 32'h0000_0000, 32'h0, 8'h0, 0, "l3_errLow");

    $display("[TB] reset during WAIT");
    applyStimulus(1'b1, 1'b1, 32'h8000_0020, 32'hCAFE_BABE, 8'hF, 1'b0, 1'b0, "l3_rstStore");
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_reqReady", 32'(rdyOf(1'b1)), 32'd1);
    checkOutput("rst_rspValid", 32'(valOf(1'b1)), 32'd0);
    checkOutput("rst_rspRdata", rdataOf(1'b1), 32'd0);
    checkOutput("rst_rspErr", 32'(errOf(1'b1)), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      checkOutput("rst_noRsp", 32'(valOf(1'b1)), 32'd0);
    end
    txn(1'b1, 1'b0, 32'h8000_0020, 32'h0, 8'h0, 0, "l3_loadAfterRst");
    checkOutput("rst_oldValueConst", lastRdata, 32'h55AA_55AA);
    txn(1'b0, 1'b0, 32'h8000_0000, 32'h0, 8'h0, 0, "l0_persist");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_ex_lsu_dmem_resp.md
Name: core_ex_lsu_dmem_resp

Overview:
- Synthesizable data-memory responder: the memory-side end of the LSU load/store interface.
- Replaces the DPI-C pmem_read/pmem_write path for FPGA and non-Verilator simulation.
- Accepts one word-aligned request at a time over a valid/ready handshake, waits a programmable latency, then returns read data or a write acknowledge over a second valid/ready handshake.
- Applies byte-masked writes from the LSU align stage (write_data_aligned, wmask).

Parameters:
- XLEN, 32, data/address width; must match CORE_XLEN.
- DEPTH_W, 12, log2 of memory depth in words (4096 words = 16 KiB).
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- LATENCY, 0, extra wait cycles between accept and response (0..15).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  responder can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  XLEN  byte address; bits [1:0] ignored.
- req_wdata  in  XLEN  aligned store data.
- req_wmask  in  8  byte-enable; bits [XLEN/8-1:0] used, upper bits ignored.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  XLEN  full word read data (loads); 0 for stores and errors.
- rsp_err  out  1  address outside [BASE_ADDR, BASE_ADDR + 4*2^DEPTH_W).

Behaviour:
- States: IDLE, WAIT, RESP. Reset value is IDLE.
- Output reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1.
- req_ready = (state==IDLE), combinational from state only. No dependence on req_valid.
- Accept occurs when req_valid & req_ready. On accept, register wen, word index (addr[DEPTH_W+1:2] - base offset), wdata, wmask and the range check.
- IDLE -> WAIT on accept if LATENCY>0, loading a counter with LATENCY. IDLE -> RESP on accept if LATENCY==0.
- WAIT decrements the counter each cycle and goes to RESP when the counter reaches 1 (exactly LATENCY cycles spent in WAIT).
- Entering RESP (same edge):
  - Store in range: write every byte lane whose mask bit is 1; other lanes unchanged.
  - Load in range: rsp_rdata <= mem[index].
  - Error: no write; rsp_rdata <= 0; rsp_err <= 1.
- Timing: accept at edge N gives rsp_valid=1 after edge N+1+LATENCY. LATENCY=0 gives 1-cycle turnaround, matching the test model.
- RESP holds rsp_valid, rsp_rdata and rsp_err stable until rsp_valid & rsp_ready. It then returns to IDLE with rsp_valid=0, rsp_err=0 and rsp_rdata held. The next accept is possible the cycle after.
- Back-to-back maximum throughput is one request per 2+LATENCY cycles. No request queuing.
- Store followed by load to the same word returns the new data; the write completes before the load is accepted.
- Byte lanes are little-endian: mask bit k controls rdata/wdata bits [8k+7:8k].
- Store with all-zero mask: response issued, memory unchanged.
- Memory array has no reset; contents persist across rst.
- rst asserted mid-operation (WAIT or RESP): state returns to IDLE immediately, pending response is dropped, outputs take reset values. A store still in WAIT is not written.
- req_* inputs are ignored outside IDLE.
- Address wrap: the range check uses full XLEN unsigned compare. No aliasing.

Test Plan:
- LATENCY=0: store addr 0x8000_0010, wdata 0xDEADBEEF, mask 0xF, rsp_ready=1 -> rsp_valid one cycle after accept, rsp_err=0. Then load same addr -> rsp_rdata=0xDEADBEEF.
- Byte mask: store 0x11223344 mask 0x2 onto word holding 0xDEADBEEF -> load returns 0xDEAD33EF. Mask 0x0 -> word unchanged.
- LATENCY=3: accept at cycle 10 -> rsp_valid first high at cycle 14. req_ready=0 on cycles 11..14 while req_valid is held high.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable and req_ready=0 throughout. Handshake on cycle 6, then req_ready=1.
- Error: load 0x7FFF_FFFC and store 0x8001_0000 -> rsp_err=1, rsp_rdata=0, no memory word modified (readback of word 0 unchanged).
- Reset mid-WAIT (LATENCY=3) during a store of 0xCAFEBABE -> rsp_valid never asserts, req_ready=1 after reset, later load of that address returns the old value.
